// File: rtl/multdiv_issue.sv
// Request sequencer in front of the iterative multiplier/divider: latches operands, issues a
// one-cycle start pulse, waits for the unit and holds the response. Option: MULTDIV_TIMEOUT_EN.
module multdiv_issue #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_div,
  input  logic [WIDTH-1:0] req_opA,
  input  logic [WIDTH-1:0] req_opB,
  output logic [WIDTH-1:0] unit_operandA,
  output logic [WIDTH-1:0] unit_operandB,
  output logic             unit_ctrl_MULT,
  output logic             unit_ctrl_DIV,
  input  logic [WIDTH-1:0] unit_result,
  input  logic             unit_exception,
  input  logic             unit_resultRDY,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_exception,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             is_div_q, is_div_d;
  logic             exc_q, exc_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic             ctrl_mult_q, ctrl_mult_d;
  logic             ctrl_div_q, ctrl_div_d;
  logic             req_fire_s;
  logic             resp_fire_s;
  logic             div_zero_s;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);
  logic [5:0] cnt_q, cnt_d;
`endif

  assign req_fire_s  = req_valid & req_ready_q;
  assign resp_fire_s = resp_valid_q & resp_ready;
  assign div_zero_s  = req_is_div & (req_opB == {WIDTH{1'b0}});

  // Next-state, operand/result capture and registered-output decode
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    res_d    = res_q;
    exc_d    = exc_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire_s) begin
          opa_d    = req_opA;
          opb_d    = req_opB;
          is_div_d = req_is_div;
          if (div_zero_s) begin
            // Divide by zero never reaches the unit
            res_d   = {WIDTH{1'b0}};
            exc_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_START;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (unit_resultRDY) begin
          res_d   = unit_result;
          exc_d   = unit_exception;
          state_d = ST_DONE;
        end else begin
`ifdef MULTDIV_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            res_d   = {WIDTH{1'b0}};
            exc_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_DONE: begin
        if (resp_fire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    ctrl_div_d   = (state_d == ST_START) & is_div_d;
    ctrl_mult_d  = (state_d == ST_START) & ~is_div_d;
  end

`ifdef MULTDIV_TIMEOUT_EN
  // Watchdog counter: zero outside WAIT, counts WAIT cycles
  always_comb begin
    cnt_d = 6'd0;
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 6'd1;
    end else begin
      cnt_d = 6'd0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State, datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      opa_q        <= {WIDTH{1'b0}};
      opb_q        <= {WIDTH{1'b0}};
      res_q        <= {WIDTH{1'b0}};
      is_div_q     <= 1'b0;
      exc_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ctrl_mult_q  <= 1'b0;
      ctrl_div_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      res_q        <= res_d;
      is_div_q     <= is_div_d;
      exc_q        <= exc_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      ctrl_mult_q  <= ctrl_mult_d;
      ctrl_div_q   <= ctrl_div_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign busy           = busy_q;
  assign resp_valid     = resp_valid_q;
  assign resp_result    = res_q;
  assign resp_exception = exc_q;
  assign unit_operandA  = opa_q;
  assign unit_operandB  = opb_q;
  assign unit_ctrl_MULT = ctrl_mult_q;
  assign unit_ctrl_DIV  = ctrl_div_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed self-checking bench for multdiv_issue; the unit is modelled by hand-timed RDY pulses.
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_is_div;
  logic [31:0] req_opA, req_opB;
  logic [31:0] unit_operandA, unit_operandB;
  logic        unit_ctrl_MULT, unit_ctrl_DIV;
  logic [31:0] unit_result;
  logic        unit_exception, unit_resultRDY;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_exception, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multdiv_issue #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_div(req_is_div),
    .req_opA(req_opA), .req_opB(req_opB),
    .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
    .unit_ctrl_MULT(unit_ctrl_MULT), .unit_ctrl_DIV(unit_ctrl_DIV),
    .unit_result(unit_result), .unit_exception(unit_exception), .unit_resultRDY(unit_resultRDY),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_exception(resp_exception), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request; RDY comes lat cycles after the pulse cycle (plus a bogus RDY in START).
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic dv, input int lat, input logic give_rdy,
                       input logic [31:0] ures, input logic uexc,
                       input logic exp_done, input logic [31:0] eres, input logic eexc);
    int ndiv, nmult, first, opbad;
    ndiv = 0; nmult = 0; first = -1; opbad = 0;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_opA = a; req_opB = b; req_is_div = dv;
    step();
    req_valid = 1'b0; req_opA = ~a; req_opB = ~b; req_is_div = ~dv;
    for (int i = 1; i <= lat + 2; i++) begin
      ndiv  += int'(unit_ctrl_DIV);
      nmult += int'(unit_ctrl_MULT);
      if (resp_valid && first < 0) first = i;
      if (unit_operandA !== a || unit_operandB !== b) opbad++;
      if (give_rdy && i == 1) begin
        unit_resultRDY = 1'b1; unit_result = 32'hDEAD_BEEF; unit_exception = 1'b1;
      end else if (give_rdy && i == lat + 1) begin
        unit_resultRDY = 1'b1; unit_result = ures; unit_exception = uexc;
      end else begin
        unit_resultRDY = 1'b0; unit_result = 32'h0BAD_0BAD; unit_exception = 1'b1;
      end
      if (i < lat + 2) step();
    end
    unit_resultRDY = 1'b0;
    chk({tag, "_div_pulses"}, 32'(ndiv), 32'(dv));
    chk({tag, "_mult_pulses"}, 32'(nmult), 32'(!dv));
    chk({tag, "_operands_stable"}, 32'(opbad), 32'd0);
    chk({tag, "_first_valid"}, 32'(first), exp_done ? 32'(lat + 2) : 32'hFFFF_FFFF);
    if (exp_done) begin
      chk({tag, "_result"}, resp_result, eres);
      chk({tag, "_exception"}, 32'(resp_exception), 32'(eexc));
      unit_resultRDY = 1'b1; unit_result = 32'h5555_5555; unit_exception = ~eexc;
      step();
      unit_resultRDY = 1'b0;
      chk({tag, "_late_rdy_result"}, resp_result, eres);
      chk({tag, "_late_rdy_exc"}, 32'(resp_exception), 32'(eexc));
    end
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_hs_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_hs_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int hold_bad;
    reset_n = 1'b0; req_valid = 1'b0; req_is_div = 1'b0; req_opA = 32'd0; req_opB = 32'd0;
    unit_result = 32'd0; unit_exception = 1'b0; unit_resultRDY = 1'b0; resp_ready = 1'b0;
    step(); step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    chk("rst_opA", unit_operandA, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rel_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);

    // 100 / 7 = 14
    do_op("div", 32'd100, 32'd7, 1'b1, 33, 1'b1, 32'd14, 1'b0, 1'b1, 32'd14, 1'b0);
    finish_resp("div");

    // -3 * 5 = -15
    do_op("mult", 32'hFFFF_FFFD, 32'd5, 1'b0, 17, 1'b1, 32'hFFFF_FFF1, 1'b0,
          1'b1, 32'hFFFF_FFF1, 1'b0);

    // Response held while a new request is pending
    hold_bad = 0;
    req_valid = 1'b1; req_is_div = 1'b0; req_opB = 32'd3;
    for (int i = 0; i < 10; i++) begin
      req_opA = 32'(i * 11 + 1);
      step();
      if (resp_valid !== 1'b1 || resp_result !== 32'hFFFF_FFF1 || resp_exception !== 1'b0 ||
          req_ready !== 1'b0 || unit_operandA !== 32'hFFFF_FFFD || unit_ctrl_MULT !== 1'b0)
        hold_bad++;
    end
    chk("hold_stable", 32'(hold_bad), 32'd0);
    req_opA = 32'd21;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("hold_hs_req_ready", 32'(req_ready), 32'd1);
    chk("hold_hs_busy", 32'(busy), 32'd0);
    chk("hold_hs_no_pulse", 32'(unit_ctrl_MULT), 32'd0);
    step();
    req_valid = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_mult_pulse", 32'(unit_ctrl_MULT), 32'd1);
    chk("b2b_opA", unit_operandA, 32'd21);
    chk("b2b_req_ready", 32'(req_ready), 32'd0);

    // Reset pulse while in WAIT
    step(); step();
    reset_n = 1'b0;
    #1;
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_opA", unit_operandA, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("mrst_rel_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    unit_resultRDY = 1'b1; unit_result = 32'd77; unit_exception = 1'b0;
    step();
    unit_resultRDY = 1'b0;
    chk("mrst_late_rdy_valid", 32'(resp_valid), 32'd0);
    chk("mrst_late_rdy_busy", 32'(busy), 32'd0);
    chk("mrst_late_rdy_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    chk("mrst_result", resp_result, 32'd0);

    // 9 / 0: immediate exception
    chk("dz_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_div = 1'b1; req_opA = 32'd9; req_opB = 32'd0;
    step();
    req_valid = 1'b0;
    chk("dz_valid", 32'(resp_valid), 32'd1);
    chk("dz_exception", 32'(resp_exception), 32'd1);
    chk("dz_result", resp_result, 32'd0);
    chk("dz_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    chk("dz_opA", unit_operandA, 32'd9);
    step();
    chk("dz_ctrl2", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    chk("dz_valid2", 32'(resp_valid), 32'd1);
    finish_resp("dz");

    // Unit-reported exception (signed overflow case) is passed through
    do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5, 1'b1, 32'h8000_0000, 1'b1,
          1'b1, 32'h8000_0000, 1'b1);
    finish_resp("ovf");

`ifdef MULTDIV_TIMEOUT_EN
    do_op("tmo", 32'd50, 32'd5, 1'b1, 40, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
    finish_resp("tmo");
    do_op("rdy40", 32'd50, 32'd5, 1'b1, 40, 1'b1, 32'd10, 1'b0, 1'b1, 32'd10, 1'b0);
    finish_resp("rdy40");
`else
    do_op("persist", 32'd50, 32'd5, 1'b1, 60, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("persist_busy", 32'(busy), 32'd1);
    unit_resultRDY = 1'b1; unit_result = 32'd10; unit_exception = 1'b0;
    step();
    unit_resultRDY = 1'b0;
    chk("persist_valid", 32'(resp_valid), 32'd1);
    chk("persist_result", resp_result, 32'd10);
    finish_resp("persist");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
